// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 receive front end.
//   - ps2_state_e   : frame deserialiser FSM states
//   - PS2_* consts  : PS/2 device-to-host frame layout
//   - odd_parity_ok : true when data bits plus parity bit hold an odd number of ones
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam int   PS2_DATA_BITS = 8;
  localparam logic PS2_START_BIT = 1'b0;
  localparam logic PS2_STOP_BIT  = 1'b1;

  // PS/2 uses odd parity: the XOR of all eight data bits and the parity bit is 1.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: brings one raw, asynchronous PS/2 pin into the clock domain
// and removes glitches.
//   clock : system clock
//   reset : asynchronous active-low reset
//   pin   : raw pin level (asynchronous)
//   level : filtered level; resets to 1 (idle bus level)
// The synchronised level must differ from the filtered level for FILTER_LEN
// consecutive cycles before the filtered level follows it.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic level
);

  localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

  logic       sync1_reg;
  logic       sync2_reg;
  logic       level_reg;
  logic [3:0] cnt_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b1;
      cnt_reg   <= 4'd0;
    end else begin
      sync1_reg <= pin;
      sync2_reg <= sync1_reg;
      if (sync2_reg == level_reg) begin
        cnt_reg <= 4'd0;
      end else if (cnt_reg == CNT_LAST) begin
        // This is the FILTER_LEN-th consecutive differing sample.
        level_reg <= sync2_reg;
        cnt_reg   <= 4'd0;
      end else begin
        cnt_reg <= cnt_reg + 4'd1;
      end
    end
  end

  assign level = level_reg;

endmodule

// File: rtl/ps2_rx_frontend.sv
// ps2_rx_frontend: PS/2 device-to-host receiver front end.
//   clock      : system clock
//   reset      : asynchronous active-low reset
//   ps2_clk    : raw PS/2 clock pin
//   ps2_data   : raw PS/2 data pin
//   out_valid  : holding register contains a byte
//   out_ready  : consumer accepts the byte this cycle
//   out_data   : received scancode byte
//   err_parity : 1-cycle pulse, frame dropped for even parity
//   err_frame  : 1-cycle pulse, frame dropped for stop=0 or timeout
//   overrun    : 1-cycle pulse, good byte dropped because holding register full
// Both pins are synchronised and filtered, frames are deserialised on falling
// edges of the filtered clock, and good bytes go into a one-entry holding
// register with a valid/ready interface.
module ps2_rx_frontend
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overrun
);

  localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);
  localparam logic [2:0]  LAST_BIT      = 3'(PS2_DATA_BITS - 1);

  logic clk_level;
  logic data_level;
  logic clk_level_prev_reg;
  logic strobe;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clock (clock),
    .reset (reset),
    .pin   (ps2_clk),
    .level (clk_level)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clock (clock),
    .reset (reset),
    .pin   (ps2_data),
    .level (data_level)
  );

  // Bit strobe: the cycle in which the filtered clock has just fallen.
  assign strobe = clk_level_prev_reg & ~clk_level;

  ps2_state_e  state_reg,   state_next;
  logic [7:0]  shift_reg,   shift_next;
  logic [2:0]  bit_idx_reg, bit_idx_next;
  logic        parity_reg,  parity_next;
  logic [16:0] timeout_reg, timeout_next;
  logic        push_good;
  logic        err_parity_next;
  logic        err_frame_next;
  logic        load;
  logic        out_valid_reg;
  logic [7:0]  out_data_reg;
  logic        err_parity_reg;
  logic        err_frame_reg;
  logic        overrun_reg;

  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    bit_idx_next    = bit_idx_reg;
    parity_next     = parity_reg;
    timeout_next    = timeout_reg;
    push_good       = 1'b0;
    err_parity_next = 1'b0;
    err_frame_next  = 1'b0;

    if (state_reg != ST_IDLE) begin
      timeout_next = timeout_reg + 17'd1;
    end

    if (state_reg != ST_IDLE && timeout_reg == TIMEOUT_LIMIT) begin
      // Device went quiet mid-frame: discard the partial frame.
      state_next     = ST_IDLE;
      shift_next     = 8'd0;
      bit_idx_next   = 3'd0;
      timeout_next   = 17'd0;
      err_frame_next = 1'b1;
    end else if (strobe) begin
      timeout_next = 17'd0;
      case (state_reg)
        ST_IDLE: begin
          if (data_level == PS2_START_BIT) begin
            state_next   = ST_DATA;
            bit_idx_next = 3'd0;
            shift_next   = 8'd0;
          end
        end
        ST_DATA: begin
          shift_next   = {data_level, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == LAST_BIT) begin
            state_next = ST_PARITY;
          end
        end
        ST_PARITY: begin
          parity_next = data_level;
          state_next  = ST_STOP;
        end
        ST_STOP: begin
          state_next = ST_IDLE;
          // A bad stop bit outranks a parity failure.
          if (data_level != PS2_STOP_BIT) begin
            err_frame_next = 1'b1;
          end else if (!odd_parity_ok(shift_reg, parity_reg)) begin
            err_parity_next = 1'b1;
          end else begin
            push_good = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // A push succeeds if the register is empty or is being drained this cycle.
  assign load = push_good & (~out_valid_reg | out_ready);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_level_prev_reg <= 1'b1;
      state_reg          <= ST_IDLE;
      shift_reg          <= 8'd0;
      bit_idx_reg        <= 3'd0;
      parity_reg         <= 1'b0;
      timeout_reg        <= 17'd0;
      out_valid_reg      <= 1'b0;
      out_data_reg       <= 8'd0;
      err_parity_reg     <= 1'b0;
      err_frame_reg      <= 1'b0;
      overrun_reg        <= 1'b0;
    end else begin
      clk_level_prev_reg <= clk_level;
      state_reg          <= state_next;
      shift_reg          <= shift_next;
      bit_idx_reg        <= bit_idx_next;
      parity_reg         <= parity_next;
      timeout_reg        <= timeout_next;
      err_parity_reg     <= err_parity_next;
      err_frame_reg      <= err_frame_next;
      overrun_reg        <= push_good & ~load;
      if (load) begin
        out_data_reg  <= shift_reg;
        out_valid_reg <= 1'b1;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign err_parity = err_parity_reg;
  assign err_frame  = err_frame_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_ps2_rx_frontend.sv
// tb_ps2_rx_frontend: drives PS/2 frames onto the raw pins and checks received
// bytes and error pulses against a frame-level reference model.
module tb_ps2_rx_frontend;

  localparam int FLEN = 8;
  localparam int TMO  = 2000;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       err_parity;
  logic       err_frame;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor state (written only by the monitor process).
  int   n_perr = 0;
  int   n_ferr = 0;
  int   n_ovr = 0;
  int   n_valid = 0;
  int   n_stab = 0;
  logic [7:0] acc_q[$];
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data = 8'd0;

  ps2_rx_frontend #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clock      (clock),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .err_parity (err_parity),
    .err_frame  (err_frame),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (err_parity) n_perr++;
    if (err_frame) n_ferr++;
    if (overrun) n_ovr++;
    if (out_valid) n_valid++;
    if (out_valid && out_ready) acc_q.push_back(out_data);
    if (prev_valid && !prev_ready && out_valid && out_data != prev_data) n_stab++;
    prev_valid = out_valid;
    prev_ready = out_ready;
    prev_data  = out_data;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Frame bit 0 is the start bit, bits 1..8 the byte LSB first, then parity, stop.
  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic par,
                                             input logic stop);
    return {stop, par, b, 1'b0};
  endfunction

  // Parity bit that makes the frame good: total number of ones must be odd.
  function automatic logic good_par(input logic [7:0] b);
    return ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic send_bits(input logic [10:0] frame, input int nbits, input int h,
                           input int glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      tick(h);
      ps2_clk = 1'b0;
      tick(h);
      ps2_clk = 1'b1;
      if (i == glitch_bit) begin
        tick(5);
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
      end
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input int h, input int glitch_bit);
    $display("frame: byte=%02h parity=%0b stop=%0b half=%0d", b, par, stop, h);
    send_bits(make_frame(b, par, stop), 11, h, glitch_bit);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick(3);
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++;
    if (out_data !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %02h want 00", out_data); end
    n_checks++;
    if ({err_parity, err_frame, overrun} !== 3'b000) begin
      n_errors++; $display("FAIL reset_pulses: got %b want 000", {err_parity, err_frame, overrun});
    end
    reset = 1'b1;
    tick(30);
    n_checks++;
    if (out_valid !== 1'b0 || n_perr + n_ferr + n_ovr != 0) begin
      n_errors++; $display("FAIL post_reset_idle: valid=%b pulses=%0d want 0/0", out_valid, n_perr + n_ferr + n_ovr);
    end
  endtask

  task automatic test_basic;
    int a0, v0, p0, f0;
    a0 = acc_q.size(); v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    out_ready = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b1, 20, -1);
    tick(60);
    n_checks++;
    if (acc_q.size() != a0 + 1 || acc_q[acc_q.size()-1] !== 8'h1C) begin
      n_errors++; $display("FAIL basic_byte: got %0d bytes want 1 byte 1c", acc_q.size() - a0);
    end
    n_checks++;
    if (n_valid - v0 != 1) begin n_errors++; $display("FAIL basic_valid_cycles: got %0d want 1", n_valid - v0); end
    n_checks++;
    if (n_perr != p0 || n_ferr != f0) begin
      n_errors++; $display("FAIL basic_errors: got perr=%0d ferr=%0d want 0/0", n_perr - p0, n_ferr - f0);
    end
  endtask

  task automatic test_back_to_back;
    int a0, o0, s0;
    a0 = acc_q.size(); o0 = n_ovr; s0 = n_stab;
    out_ready = 1'b0;
    send_frame(8'hF0, good_par(8'hF0), 1'b1, 18, -1);
    send_frame(8'h1C, good_par(8'h1C), 1'b1, 18, -1);
    tick(60);
    n_checks++;
    if (n_ovr - o0 != 1) begin n_errors++; $display("FAIL b2b_overrun: got %0d want 1", n_ovr - o0); end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hF0) begin
      n_errors++; $display("FAIL b2b_hold: got valid=%b data=%02h want 1/f0", out_valid, out_data);
    end
    n_checks++;
    if (n_stab != s0) begin n_errors++; $display("FAIL b2b_stable: got %0d changes want 0", n_stab - s0); end
    out_ready = 1'b1;
    tick(3);
    n_checks++;
    if (out_valid !== 1'b0 || acc_q.size() != a0 + 1 || acc_q[acc_q.size()-1] !== 8'hF0) begin
      n_errors++; $display("FAIL b2b_drain: got valid=%b accepted=%0d want 0/1 (f0)", out_valid, acc_q.size() - a0);
    end
  endtask

  task automatic test_errors;
    int a0, p0, f0;
    a0 = acc_q.size(); p0 = n_perr; f0 = n_ferr;
    out_ready = 1'b1;
    send_frame(8'h1C, 1'b1, 1'b1, 20, -1);
    tick(60);
    n_checks++;
    if (n_perr - p0 != 1 || n_ferr != f0) begin
      n_errors++; $display("FAIL parity_err: got perr=%0d ferr=%0d want 1/0", n_perr - p0, n_ferr - f0);
    end
    send_frame(8'h1C, 1'b1, 1'b0, 20, -1);
    tick(60);
    n_checks++;
    if (n_ferr - f0 != 1 || n_perr - p0 != 1) begin
      n_errors++; $display("FAIL stop_err: got ferr=%0d perr=%0d want 1/1", n_ferr - f0, n_perr - p0);
    end
    n_checks++;
    if (acc_q.size() != a0) begin n_errors++; $display("FAIL err_no_byte: got %0d bytes want 0", acc_q.size() - a0); end
  endtask

  task automatic test_timeout;
    int a0, f0;
    a0 = acc_q.size(); f0 = n_ferr;
    out_ready = 1'b1;
    $display("partial frame: start + 5 data bits then idle");
    send_bits(make_frame(8'h3B, 1'b0, 1'b1), 6, 20, -1);
    tick(TMO + 10);
    n_checks++;
    if (n_ferr - f0 != 1) begin n_errors++; $display("FAIL timeout_err: got %0d want 1", n_ferr - f0); end
    send_frame(8'h5A, good_par(8'h5A), 1'b1, 20, -1);
    tick(60);
    n_checks++;
    if (acc_q.size() != a0 + 1 || acc_q[acc_q.size()-1] !== 8'h5A || n_ferr - f0 != 1) begin
      n_errors++; $display("FAIL timeout_recover: got %0d bytes ferr=%0d want 1 byte 5a ferr=1", acc_q.size() - a0, n_ferr - f0);
    end
  endtask

  task automatic test_glitch;
    int a0, e0;
    a0 = acc_q.size(); e0 = n_perr + n_ferr;
    out_ready = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b1, 25, 4);
    tick(60);
    n_checks++;
    if (acc_q.size() != a0 + 1 || acc_q[acc_q.size()-1] !== 8'h1C || n_perr + n_ferr != e0) begin
      n_errors++; $display("FAIL glitch: got %0d bytes errs=%0d want 1 byte 1c no errs", acc_q.size() - a0, n_perr + n_ferr - e0);
    end
  endtask

  task automatic test_reset_midframe;
    int a0, bad;
    bad = 0;
    out_ready = 1'b0;
    send_frame(8'h5A, good_par(8'h5A), 1'b1, 20, -1);
    tick(40);
    $display("partial frame: start + 4 data bits then reset");
    send_bits(make_frame(8'h77, 1'b0, 1'b1), 5, 20, -1);
    reset = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (out_valid !== 1'b0 || out_data !== 8'h00) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL reset_mid_outputs: got %0d bad cycles want 0", bad); end
    reset = 1'b1;
    out_ready = 1'b1;
    tick(20);
    a0 = acc_q.size();
    send_frame(8'h29, 1'b0, 1'b1, 20, -1);
    tick(60);
    n_checks++;
    if (acc_q.size() != a0 + 1 || acc_q[acc_q.size()-1] !== 8'h29) begin
      n_errors++; $display("FAIL reset_mid_byte: got %0d bytes want 1 byte 29", acc_q.size() - a0);
    end
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic       par, stop;
    int kind, a0, p0, f0, exp_p, exp_f, mism;
    a0 = acc_q.size(); p0 = n_perr; f0 = n_ferr;
    exp_p = 0; exp_f = 0; mism = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      b    = 8'($urandom);
      kind = int'($urandom_range(0, 2));
      par  = (kind == 1) ? ~good_par(b) : good_par(b);
      stop = (kind == 2) ? 1'b0 : 1'b1;
      // Reference: classify the frame from its bits.
      if (stop == 1'b0) exp_f++;
      else if (($countones(b) + int'(par)) % 2 == 0) exp_p++;
      else exp_q.push_back(b);
      send_frame(b, par, stop, int'($urandom_range(15, 40)), -1);
      tick(int'($urandom_range(0, 30)));
    end
    tick(80);
    n_checks++;
    if (acc_q.size() - a0 != exp_q.size()) begin
      n_errors++; $display("FAIL random_count: got %0d bytes want %0d", acc_q.size() - a0, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) if (acc_q[a0 + i] !== exp_q[i]) mism++;
      n_checks++;
      if (mism != 0) begin n_errors++; $display("FAIL random_bytes: got %0d wrong bytes want 0", mism); end
    end
    n_checks++;
    if (n_perr - p0 != exp_p || n_ferr - f0 != exp_f) begin
      n_errors++; $display("FAIL random_errors: got perr=%0d ferr=%0d want %0d/%0d", n_perr - p0, n_ferr - f0, exp_p, exp_f);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_errors();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx_frontend.md
# ps2_rx_frontend

Receives raw PS/2 device-to-host frames on the asynchronous `ps2_clk`/`ps2_data` pins. Synchronises and de-glitches both lines into the `clock` domain, then deserialises 11-bit frames and checks start, odd parity and stop bits. Each good scancode byte is presented on a valid/ready port. It sits directly upstream of the PS/2 APB scancode FIFO, so that FIFO needs no `ps2_clk`-domain logic.

## Interface
- `FILTER_LEN`, 8: consecutive identical synchronised samples required before a filtered line changes; range 1..15.
- `TIMEOUT_CYCLES`, 100000: idle `clock` cycles allowed between falling edges inside a frame (2 ms at 50 MHz); must fit 17 bits.
- `clock`  in  1  system clock; every flop is clocked on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `out_valid`  out  1  holding register contains a byte.
- `out_ready`  in  1  consumer accepts the byte on the current cycle.
- `out_data`  out  8  received scancode byte.
- `err_parity`  out  1  one-cycle pulse: frame dropped because parity was even.
- `err_frame`  out  1  one-cycle pulse: frame dropped because the stop bit was 0 or the frame timed out.
- `overrun`  out  1  one-cycle pulse: a good byte was dropped because the holding register was full.

## Operation
- Input path: each pin goes through a 2-flop synchroniser, then a saturating filter counter.
  - The filtered level takes the synchronised level once that level has differed from the filtered level for `FILTER_LEN` consecutive cycles.
  - The counter clears whenever the synchronised level equals the filtered level.
  - Filtered levels reset to 1.
- Bit strobe: the cycle in which filtered clk goes from 1 to 0. Filtered data is sampled in that same cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: a strobe with data=0 goes to DATA and clears the bit index. A strobe with data=1 is ignored silently.
  - DATA: shift the bit in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: store the parity bit, then go to STOP.
  - STOP: return to IDLE.
    - If stop=1 and (popcount(data)+parity) is odd, the byte is good.
    - If stop=0, pulse `err_frame`; this takes priority over a parity failure.
    - Else, if parity is even, pulse `err_parity`.
- Timeout: a 17-bit counter clears on every strobe and on entry to IDLE. It counts in DATA, PARITY and STOP. When it reaches `TIMEOUT_CYCLES`:
  - the FSM goes to IDLE;
  - the partial frame is discarded;
  - `err_frame` pulses once.
- Holding register, 1 entry:
  - A good byte loads `out_data` and sets `out_valid` if the register is empty, or if `out_ready` is high in the same cycle (simultaneous pop and push is allowed).
  - Otherwise the new byte is dropped, the old byte is kept, and `overrun` pulses.
  - `out_valid` clears when `out_ready` is sampled high and no push occurs.
  - `out_data` is stable while `out_valid` is high and `out_ready` is low.
- Reset, including assertion mid-frame:
  - FSM goes to IDLE; shift register, bit index and timeout counter clear.
  - `out_valid`=0, `out_data`=0, all error/overrun pulses 0.
  - Filtered levels =1; synchroniser flops =1.
  - After release, bits of the interrupted frame are parsed fresh: data=1 is ignored; data=0 starts a bogus frame, which is rejected by parity, stop or timeout.

## Timing
- Pin edge to strobe: 2 synchroniser cycles plus `FILTER_LEN` cycles.
- Stop-bit strobe to `out_valid`=1 (or to an error pulse): 1 cycle, registered.
- Error and overrun outputs are registered, exactly 1 cycle wide, at most one per frame.
- Handshake: transfer when `out_valid` && `out_ready` at a rising edge. No combinational path from `out_ready` to `out_valid`.
- Throughput: one byte per frame. Back-to-back frames with no idle time between stop and the next start are supported.

## Structure
- Shared package `ps2_pkg`:
  - FSM state enum;
  - PS/2 frame constants (`PS2_DATA_BITS`=8, start=0, stop=1);
  - the odd-parity helper function.
- Sub-module `ps2_line_filter`: synchroniser plus filter counter, instantiated once for clk and once for data.
- FSM, timeout counter and holding register live in the top module.

## Test plan
- Send 0x1C, parity 0, stop 1, with `out_ready`=1 → one `out_valid` cycle with `out_data`=0x1C; no error pulses.
- Send 0xF0 (parity 1) then 0x1C back-to-back with `out_ready`=0 → `out_data` holds 0xF0 and `overrun` pulses once for 0x1C. Then raise `out_ready` → 0xF0 is accepted and `out_valid` drops.
- Send 0x1C with parity 1 → `err_parity` pulses once; `out_valid` stays 0. Send 0x1C with stop 0 → `err_frame` pulses once.
- Send start plus 5 data bits, then hold lines high for `TIMEOUT_CYCLES`+10 → `err_frame` pulses once. A following valid 0x5A frame is received correctly.
- With `FILTER_LEN`=8, drive a 3-cycle low glitch on `ps2_clk` mid-frame → no extra bit; 0x1C is still received correctly.
- Assert `reset` after the 4th data bit, release it, then send 0x29 (parity 0) → `out_data`=0x29 and `out_valid`=0 throughout reset.
